ofm_write_data_sequencer: RTL and testbench
===========================================

Name: ofm_write_data_sequencer

Overview:
Sits between the systolic array output stage and ofm_write_addr_controller. Accepts completed output tiles (up to SYSTOLIC_SIZE filters × SYSTOLIC_SIZE pixels) into a two-entry ping-pong buffer. Drains each tile as a burst of per-filter row words into OFM RAM. Generates the `write` pulse that steps the address controller, aligned so that each data word coincides with its channel address.

Parameters:
SYSTOLIC_SIZE, 16, PEs per array side; max filters per tile and max pixels per row word
DATA_WIDTH, 16, bits per OFM pixel
TILE_CNT_W, 20, width of the per-layer tile counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  layer start pulse; flushes buffers and counters
num_tiles  in  TILE_CNT_W  tiles in the current layer; sampled on start
tile_valid  in  1  tile_data holds a finished tile
tile_ready  out  1  buffer can accept a tile
tile_data  in  SYSTOLIC_SIZE*SYSTOLIC_SIZE*DATA_WIDTH  filter f, pixel p at bits [(f*SYSTOLIC_SIZE+p)*DATA_WIDTH +: DATA_WIDTH]
read_wgt_size  in  5  valid filters in the offered tile; captured with the tile
write_ofm_size  in  5  valid pixels per row word, driven by the address controller
write  out  1  burst-start pulse to the address controller
ofm_wr_en  out  1  OFM RAM write strobe
ofm_wr_data  out  SYSTOLIC_SIZE*DATA_WIDTH  one filter's row segment
ofm_wr_mask  out  SYSTOLIC_SIZE  per-pixel write enable
layer_done  out  1  one-cycle pulse after the layer's last word

Behaviour:
- Clock and reset: single clock; rst_n is asynchronous and active-low. During reset, all outputs are 0 except tile_ready, which is 1. Buffers are empty, tile count is 0, FSM is IDLE.
- Buffer: two entries. Each entry holds the tile data plus its read_wgt_size (N). Entries are managed by a write pointer, a read pointer and a 2-bit occupancy count.
  - tile_ready = (count < 2) and not done_latched.
  - A tile is accepted when tile_valid and tile_ready are both high.
  - An accept and a release in the same cycle leave count unchanged.
  - N = 0 is stored as 1. N > SYSTOLIC_SIZE is stored as SYSTOLIC_SIZE.
- FSM states: IDLE, DRAIN, COOLDOWN.
  - IDLE: when count > 0, go to DRAIN. The earliest first word comes 1 cycle after the accepting edge; all outputs are registered.
  - DRAIN: channel counter c runs 0..N-1, one word per cycle.
    - Every cycle: ofm_wr_en = 1; ofm_wr_data = filter c row of the head entry.
    - write = 1 only in the c = 0 cycle.
    - write_ofm_size is sampled in the c = 0 cycle and held for the whole burst (W).
    - ofm_wr_mask bit p = (p < W). Lanes with a 0 mask bit are driven zero. W = 0 gives mask 0, but wr_en still pulses. W > SYSTOLIC_SIZE is clamped to SYSTOLIC_SIZE.
    - After c = N-1: release the head entry, increment the tile count, go to COOLDOWN.
  - COOLDOWN: exactly 2 cycles with wr_en = 0 and write = 0. This matches the address controller's UPDATE_BASE_ADDR → IDLE return. Then go to IDLE. The next write comes no earlier than burst start + N + 2.
- Layer completion:
  - When the tile count reaches num_tiles, layer_done pulses in the first COOLDOWN cycle.
  - done_latched is then set, holding tile_ready at 0 until the next start.
  - num_tiles = 0: layer_done pulses the cycle after start.
- start: has priority over everything, including mid-burst.
  - On the following edge: buffers flushed, c = 0, tile count = 0, done_latched = 0, FSM = IDLE, wr_en/write/mask = 0.
  - tile_valid is ignored in the start cycle. A partial burst is abandoned without completion.
- Tile count width is TILE_CNT_W; the counter does not wrap within a layer.

Decomposition:
- Shared package ofm_pkg holds: SYSTOLIC_SIZE and DATA_WIDTH defaults, the FSM state encoding (IDLE/DRAIN/COOLDOWN), the COOLDOWN_CYCLES = 2 constant, and the N/W clamp function.
- One sub-module, tile_ping_pong_buffer, owns the two entries, the pointers and count, and the accept/release handshake.
- The top level owns the FSM, channel counter, mask generation, tile counter and layer_done.

Test Plan:
SYSTOLIC_SIZE=4, DATA_WIDTH=8 for all tests.
1. Reset → tile_ready=1; write, wr_en, mask and layer_done all 0. Accept one tile with N=3, write_ofm_size=4 → write at accept+1; wr_en for 3 consecutive cycles carrying filter rows 0,1,2; mask=4'b1111; 2 idle cycles follow.
2. write_ofm_size=2 at burst start, changed to 4 mid-burst → all words have mask=4'b0011 and pixel lanes 2-3 zero.
3. Three back-to-back tiles with tile_valid held high → third accept stalls (tile_ready=0) until the first burst releases its entry; bursts are separated by exactly 2 cycles; data order is preserved.
4. num_tiles=2, two tiles with N=4 → layer_done pulses once, in the cycle after the second burst's last word; tile_ready stays 0 afterwards until start.
5. start asserted in the 2nd cycle of an N=4 burst → wr_en=0 on the next edge; buffer empty; a new tile is accepted and drained normally with N taken from the new tile.
6. N=0 tile and write_ofm_size=7 → single-word burst with mask=4'b1111; num_tiles=0 at start → layer_done pulses the cycle after start.

Source files
------------

// File: rtl/ofm_pkg.sv
// Shared constants, FSM encoding and size-clamp helper for the OFM write data path.
package ofm_pkg;

   localparam int unsigned OFM_SYSTOLIC_SIZE = 16;
   localparam int unsigned OFM_DATA_WIDTH    = 16;
   localparam int unsigned COOLDOWN_CYCLES   = 2;

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      COOLDOWN
   } ofm_state_e;

   // Saturates at max_v; min_one lifts 0 to 1 for filter counts.
   function automatic logic [4:0] clamp_size(input logic [4:0] v,
                                             input logic [4:0] max_v,
                                             input logic       min_one);
      if (v > max_v)
         return max_v;
      if (min_one && (v == 5'd0))
         return 5'd1;
      return v;
   endfunction

endpackage

// File: rtl/ofm_write_data_sequencer_buffer.sv
// Two-entry ping-pong tile store with accept/release handshake.
module tile_ping_pong_buffer
   import ofm_pkg::*;
#(
   parameter int unsigned SYSTOLIC_SIZE = OFM_SYSTOLIC_SIZE,
   parameter int unsigned DATA_WIDTH    = OFM_DATA_WIDTH
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          flush_i,
   input  logic                                          block_i,
   input  logic                                          valid_i,
   output logic                                          ready_o,
   input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE*DATA_WIDTH-1:0] data_i,
   input  logic [4:0]                                    n_i,
   input  logic                                          pop_i,
   output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE*DATA_WIDTH-1:0] head_data_o,
   output logic [4:0]                                    head_n_o,
   output logic [1:0]                                    count_o
);

   logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE*DATA_WIDTH-1:0] data_q [2];
   logic [4:0] n_q [2];
   logic       wr_ptr_q;
   logic       rd_ptr_q;
   logic [1:0] cnt_q;
   logic       push;

   assign ready_o     = (cnt_q != 2'd2) && !block_i;
   assign push        = valid_i && ready_o && !flush_i;
   assign head_data_o = data_q[rd_ptr_q];
   assign head_n_o    = n_q[rd_ptr_q];
   assign count_o     = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            n_q[i]    <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= data_i;
            n_q[wr_ptr_q]    <= clamp_size(n_i, 5'(SYSTOLIC_SIZE), 1'b1);
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop_i)
            rd_ptr_q <= ~rd_ptr_q;
         unique case ({push, pop_i})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ofm_write_data_sequencer.sv
// Drains buffered output tiles as per-filter row bursts into OFM RAM, pacing the address controller.
module ofm_write_data_sequencer
   import ofm_pkg::*;
#(
   parameter int unsigned SYSTOLIC_SIZE = OFM_SYSTOLIC_SIZE,
   parameter int unsigned DATA_WIDTH    = OFM_DATA_WIDTH,
   parameter int unsigned TILE_CNT_W    = 20
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          start,
   input  logic [TILE_CNT_W-1:0]                         num_tiles,
   input  logic                                          tile_valid,
   output logic                                          tile_ready,
   input  logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE*DATA_WIDTH-1:0] tile_data,
   input  logic [4:0]                                    read_wgt_size,
   input  logic [4:0]                                    write_ofm_size,
   output logic                                          write,
   output logic                                          ofm_wr_en,
   output logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0]           ofm_wr_data,
   output logic [SYSTOLIC_SIZE-1:0]                      ofm_wr_mask,
   output logic                                          layer_done
);

   localparam int unsigned ROW_W  = SYSTOLIC_SIZE * DATA_WIDTH;
   localparam int unsigned TILE_W = SYSTOLIC_SIZE * ROW_W;

   ofm_state_e                state_q, state_d;
   logic [4:0]                c_q, c_d;
   logic [4:0]                w_q, w_d;
   logic [1:0]                cd_q, cd_d;
   logic [TILE_CNT_W-1:0]     tile_cnt_q, tile_cnt_d, tile_cnt_inc;
   logic [TILE_CNT_W-1:0]     num_q, num_d;
   logic                      done_q, done_d;
   logic                      write_q, write_d;
   logic                      wr_en_q, wr_en_d;
   logic                      layer_done_q, layer_done_d;
   logic [ROW_W-1:0]          data_q, data_d;
   logic [SYSTOLIC_SIZE-1:0]  mask_q, mask_d;

   logic                      pop, emit, begin_burst;
   logic [1:0]                buf_count;
   logic [TILE_W-1:0]         head_data;
   logic [4:0]                head_n;
   logic [ROW_W-1:0]          row_sel;

   tile_ping_pong_buffer #(
      .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (start),
      .block_i     (done_q),
      .valid_i     (tile_valid),
      .ready_o     (tile_ready),
      .data_i      (tile_data),
      .n_i         (read_wgt_size),
      .pop_i       (pop),
      .head_data_o (head_data),
      .head_n_o    (head_n),
      .count_o     (buf_count)
   );

   always_comb begin
      state_d      = state_q;
      c_d          = c_q;
      w_d          = w_q;
      cd_d         = cd_q;
      tile_cnt_d   = tile_cnt_q;
      num_d        = num_q;
      done_d       = done_q;
      pop          = 1'b0;
      emit         = 1'b0;
      begin_burst  = 1'b0;
      write_d      = 1'b0;
      layer_done_d = 1'b0;
      tile_cnt_inc = (tile_cnt_q == '1) ? tile_cnt_q : tile_cnt_q + 1'b1;

      if (start) begin
         state_d      = IDLE;
         c_d          = '0;
         cd_d         = '0;
         tile_cnt_d   = '0;
         num_d        = num_tiles;
         done_d       = (num_tiles == '0);
         layer_done_d = (num_tiles == '0);
      end else begin
         unique case (state_q)
            IDLE: begin_burst = (buf_count != 2'd0);
            DRAIN: begin
               if (c_q == head_n - 5'd1) begin
                  pop        = 1'b1;
                  tile_cnt_d = tile_cnt_inc;
                  if (tile_cnt_inc == num_q) begin
                     layer_done_d = 1'b1;
                     done_d       = 1'b1;
                  end
                  state_d = COOLDOWN;
                  cd_d    = '0;
               end else begin
                  c_d  = c_q + 5'd1;
                  emit = 1'b1;
               end
            end
            COOLDOWN: begin
               // The IDLE check is folded into the last cooldown cycle so back-to-back bursts are exactly two cycles apart.
               if (cd_q == 2'(COOLDOWN_CYCLES - 1)) begin
                  if (buf_count != 2'd0)
                     begin_burst = 1'b1;
                  else
                     state_d = IDLE;
               end else begin
                  cd_d = cd_q + 2'd1;
               end
            end
            default: state_d = IDLE;
         endcase

         if (begin_burst) begin
            state_d = DRAIN;
            c_d     = '0;
            w_d     = clamp_size(write_ofm_size, 5'(SYSTOLIC_SIZE), 1'b0);
            write_d = 1'b1;
            emit    = 1'b1;
         end
      end

      wr_en_d = emit;
      row_sel = ROW_W'(head_data >> (ROW_W * c_d));
      for (int unsigned p = 0; p < SYSTOLIC_SIZE; p++) begin
         mask_d[p]                       = emit && (p < 32'(w_d));
         data_d[p*DATA_WIDTH +: DATA_WIDTH] = mask_d[p] ? row_sel[p*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         c_q          <= '0;
         w_q          <= '0;
         cd_q         <= '0;
         tile_cnt_q   <= '0;
         num_q        <= '0;
         done_q       <= 1'b0;
         write_q      <= 1'b0;
         wr_en_q      <= 1'b0;
         layer_done_q <= 1'b0;
         data_q       <= '0;
         mask_q       <= '0;
      end else begin
         state_q      <= state_d;
         c_q          <= c_d;
         w_q          <= w_d;
         cd_q         <= cd_d;
         tile_cnt_q   <= tile_cnt_d;
         num_q        <= num_d;
         done_q       <= done_d;
         write_q      <= write_d;
         wr_en_q      <= wr_en_d;
         layer_done_q <= layer_done_d;
         data_q       <= data_d;
         mask_q       <= mask_d;
      end
   end

   assign write       = write_q;
   assign ofm_wr_en   = wr_en_q;
   assign ofm_wr_data = data_q;
   assign ofm_wr_mask = mask_q;
   assign layer_done  = layer_done_q;

endmodule

// File: tb/tb_ofm_write_data_sequencer.sv
// Scoreboard bench for ofm_write_data_sequencer at SYSTOLIC_SIZE=4, DATA_WIDTH=8.
module tb_ofm_write_data_sequencer;

   localparam int S  = 4;
   localparam int DW = 8;

   typedef struct {
      logic          first;
      logic [S*DW-1:0] data;
      logic [S-1:0]  mask;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [19:0]       num_tiles = '0;
   logic              tile_valid = 1'b0;
   logic              tile_ready;
   logic [S*S*DW-1:0] tile_data = '0;
   logic [4:0]        read_wgt_size = '0;
   logic [4:0]        write_ofm_size = '0;
   logic              write;
   logic              ofm_wr_en;
   logic [S*DW-1:0]   ofm_wr_data;
   logic [S-1:0]      ofm_wr_mask;
   logic              layer_done;

   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   word_cnt = 0;
   int   last_wr_cyc = 0;
   int   ld_cnt = 0;
   int   ld_cyc = 0;
   int   burst_cyc[$];
   exp_t sb[$];

   ofm_write_data_sequencer #(
      .SYSTOLIC_SIZE (S),
      .DATA_WIDTH    (DW),
      .TILE_CNT_W    (20)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .num_tiles      (num_tiles),
      .tile_valid     (tile_valid),
      .tile_ready     (tile_ready),
      .tile_data      (tile_data),
      .read_wgt_size  (read_wgt_size),
      .write_ofm_size (write_ofm_size),
      .write          (write),
      .ofm_wr_en      (ofm_wr_en),
      .ofm_wr_data    (ofm_wr_data),
      .ofm_wr_mask    (ofm_wr_mask),
      .layer_done     (layer_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (ofm_wr_en) begin
            word_cnt++;
            last_wr_cyc = cyc;
            if (write)
               burst_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               check_val("unexpected_word", 64'(ofm_wr_data), 64'(0));
            end else begin
               e = sb.pop_front();
               check_val("wr_data", 64'(ofm_wr_data), 64'(e.data));
               check_val("wr_mask", 64'(ofm_wr_mask), 64'(e.mask));
               check_val("write_pulse", 64'(write), 64'(e.first));
            end
         end else if (write) begin
            check_val("write_without_wr_en", 64'(write), 64'(0));
         end
         if (layer_done) begin
            ld_cnt++;
            ld_cyc = cyc;
         end
      end
   end

   // Drives a tile (called at a negedge), pushes its expected words, returns after the accepting edge.
   task automatic send_tile(input int tid, input int n, input int w, output int acc);
      int   k;
      int   ne;
      int   we;
      exp_t e;
      for (int f = 0; f < S; f++)
         for (int p = 0; p < S; p++)
            tile_data[(f*S+p)*DW +: DW] = 8'(tid*16 + f*4 + p);
      read_wgt_size  = 5'(n);
      write_ofm_size = 5'(w);
      tile_valid     = 1'b1;
      k = 0;
      while (!tile_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (k >= 100)
         check_val("accept_timeout", 64'(tile_ready), 64'(1));
      ne = (n == 0) ? 1 : ((n > S) ? S : n);
      we = (w > S) ? S : w;
      for (int c = 0; c < ne; c++) begin
         e.first = (c == 0);
         for (int p = 0; p < S; p++) begin
            e.mask[p]          = (p < we);
            e.data[p*DW +: DW] = (p < we) ? 8'(tid*16 + c*4 + p) : 8'h00;
         end
         sb.push_back(e);
      end
      @(negedge clk);
      acc = cyc;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (k >= 300)
         check_val("drain_timeout", 64'(sb.size()), 64'(0));
      repeat (4) @(negedge clk);
   endtask

   task automatic do_start(input int nt);
      start     = 1'b1;
      num_tiles = 20'(nt);
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int a1, a2, a3, k, wc;

      repeat (3) @(negedge clk);
      check_val("rst_tile_ready", 64'(tile_ready), 64'(1));
      check_val("rst_write", 64'(write), 64'(0));
      check_val("rst_wr_en", 64'(ofm_wr_en), 64'(0));
      check_val("rst_mask", 64'(ofm_wr_mask), 64'(0));
      check_val("rst_layer_done", 64'(layer_done), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      do_start(100);

      // 1: single tile, N=3, full width
      burst_cyc.delete();
      wc = word_cnt;
      send_tile(1, 3, 4, a1);
      tile_valid = 1'b0;
      wait_drain();
      check_val("t1_words", 64'(word_cnt - wc), 64'(3));
      check_val("t1_first_latency", 64'(burst_cyc[0]), 64'(a1 + 1));

      // 2: width sampled at burst start, later change ignored
      send_tile(2, 3, 2, a1);
      tile_valid = 1'b0;
      k = 0;
      while (!write && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_val("t2_burst_seen", 64'(write), 64'(1));
      write_ofm_size = 5'd4;
      wait_drain();

      // 3: back-to-back tiles with valid held high
      burst_cyc.delete();
      send_tile(1, 3, 4, a1);
      send_tile(2, 3, 4, a2);
      check_val("t3_second_accept", 64'(a2), 64'(a1 + 1));
      check_val("t3_stall_ready", 64'(tile_ready), 64'(0));
      send_tile(3, 3, 4, a3);
      tile_valid = 1'b0;
      check_val("t3_third_accept", 64'(a3), 64'(a1 + 5));
      wait_drain();
      check_val("t3_bursts", 64'(burst_cyc.size()), 64'(3));
      if (burst_cyc.size() == 3) begin
         check_val("t3_gap_a", 64'(burst_cyc[1] - burst_cyc[0]), 64'(5));
         check_val("t3_gap_b", 64'(burst_cyc[2] - burst_cyc[1]), 64'(5));
      end
      check_val("t3_no_layer_done", 64'(ld_cnt), 64'(0));

      // 4: layer completion after two N=4 tiles
      do_start(2);
      send_tile(4, 4, 4, a1);
      send_tile(5, 4, 4, a2);
      tile_valid = 1'b0;
      wait_drain();
      check_val("t4_done_count", 64'(ld_cnt), 64'(1));
      check_val("t4_done_cycle", 64'(ld_cyc), 64'(last_wr_cyc + 1));
      check_val("t4_ready_low", 64'(tile_ready), 64'(0));
      repeat (3) @(negedge clk);
      check_val("t4_ready_still_low", 64'(tile_ready), 64'(0));

      // 5: start in the second cycle of an N=4 burst
      do_start(100);
      check_val("t5_ready_after_start", 64'(tile_ready), 64'(1));
      send_tile(6, 4, 4, a1);
      tile_valid = 1'b0;
      k = 0;
      while (!write && k < 50) begin
         @(negedge clk);
         k++;
      end
      check_val("t5_burst_seen", 64'(write), 64'(1));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("t5_abort_wr_en", 64'(ofm_wr_en), 64'(0));
      sb.delete();
      wc = word_cnt;
      repeat (6) @(negedge clk);
      check_val("t5_flushed", 64'(word_cnt - wc), 64'(0));
      check_val("t5_ready", 64'(tile_ready), 64'(1));
      send_tile(7, 2, 4, a1);
      tile_valid = 1'b0;
      wait_drain();
      check_val("t5_new_words", 64'(word_cnt - wc), 64'(2));

      // 6: N=0 and oversize width, then an empty layer
      do_start(100);
      wc = word_cnt;
      send_tile(8, 0, 7, a1);
      tile_valid = 1'b0;
      wait_drain();
      check_val("t6_single_word", 64'(word_cnt - wc), 64'(1));
      ld_cnt = 0;
      do_start(0);
      check_val("t6_empty_layer_done", 64'(layer_done), 64'(1));
      check_val("t6_empty_ready", 64'(tile_ready), 64'(0));
      @(negedge clk);
      check_val("t6_done_one_cycle", 64'(layer_done), 64'(0));
      check_val("t6_done_pulses", 64'(ld_cnt), 64'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
